alu_share_ctrl: RTL and testbench

Sequencing controller that shares the single 32-bit combinational ALU between two independent requesters (port 0: integer pipe, port 1: multi-cycle helper unit). It arbitrates round-robin, registers operands onto the ALU inputs, and holds them for a configurable settle time. It then captures the result and op-qualified flags and returns them on a per-port valid/ready response channel. The block sits between the requesters and the ALU; the ALU itself stays outside this block.

---
 rtl/alu_ctrl_pkg.sv | 58 +++++
 rtl/alu_share_ctrl_if.sv | 36 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_share_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: op codes, FSM states,
// flag layout and the op-class helpers that decide which raw ALU flags are
// allowed through to a requester.
package alu_ctrl_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned SETTLE_W = 3;

  typedef logic [OP_W-1:0] aluOp_t;

  localparam aluOp_t OP_AND  = 4'b0000;
  localparam aluOp_t OP_OR   = 4'b0001;
  localparam aluOp_t OP_XOR  = 4'b0010;
  localparam aluOp_t OP_NOT  = 4'b0011;
  localparam aluOp_t OP_ADD  = 4'b0100;
  localparam aluOp_t OP_ADC  = 4'b0101;
  localparam aluOp_t OP_ADDS = 4'b0110;
  localparam aluOp_t OP_SUBS = 4'b0111;
  localparam aluOp_t OP_SUB  = 4'b1000;
  localparam aluOp_t OP_SUBC = 4'b1001;
  localparam aluOp_t OP_SLL  = 4'b1010;
  localparam aluOp_t OP_SRL  = 4'b1011;
  localparam aluOp_t OP_SRA  = 4'b1100;
  localparam aluOp_t OP_ROL  = 4'b1101;
  localparam aluOp_t OP_ROR  = 4'b1110;
  localparam aluOp_t OP_CLZ  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrlState_t;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  // Field order matches the FLAG_* bit indices.
  typedef struct packed {
    logic c;
    logic n;
    logic v;
    logic z;
  } aluFlags_t;

  // Ops whose carry-out is architecturally meaningful.
  function automatic logic op_sets_carry(aluOp_t op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUBC);
  endfunction

  // Ops whose N/V/Z are architecturally meaningful.
  function automatic logic op_sets_nvz(aluOp_t op);
    return (op == OP_ADDS) || (op == OP_SUBS);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bundle of the ALU sharing controller: two request channels
// and two response channels (shared result/flags, per-port valid/ready).
//   master : requester view (drives req_*, rsp_ready)
//   slave  : controller view (drives req_ready, rsp_*)
interface alu_share_ctrl_if
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [OP_W-1:0]   req_op0;
  logic [OP_W-1:0]   req_op1;
  logic [W-1:0]      req_a0;
  logic [W-1:0]      req_b0;
  logic [W-1:0]      req_a1;
  logic [W-1:0]      req_b1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [FLAG_W-1:0] rsp_flags;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   reqValid : per-port request valid
//   last     : port that won the most recent completed transaction
//   grant_c  : one-hot grant (zero when nothing is requested)
module rr_arb2 (
  input  logic [1:0] reqValid,
  input  logic       last,
  output logic [1:0] grant_c
);

  // A lone requester always wins; on a tie the port that did not go last wins.
  always_comb begin
    grant_c = 2'b00;
    case (reqValid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters. A granted
// request is registered onto the ALU inputs, held for ALU_LAT cycles, and the
// result plus op-qualified flags are returned to the owning port.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : request/response channels of both ports
//   alu_op, alu_a, alu_b  : registered operation/operands to the ALU
//   alu_result, alu_c/n/v/z : ALU result and raw flags
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_ctrl_if.slave bus,
  output logic [OP_W-1:0] alu_op,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_c,
  input  logic            alu_n,
  input  logic            alu_v,
  input  logic            alu_z
);

  // Settle counter is SETTLE_W bits wide, so only 1..7 is representable.
  if ((ALU_LAT < 1) || (ALU_LAT > 7)) begin : gLatRangeCheck
    $error("alu_share_ctrl: ALU_LAT=%0d outside 1..7", ALU_LAT);
  end

  ctrlState_t          stateQ, stateD;
  logic [SETTLE_W-1:0] settleQ, settleD;
  logic                ownerQ, ownerD;
  logic                lastQ, lastD;
  aluOp_t              aluOpQ, aluOpD;
  logic [W-1:0]        aluAQ, aluAD;
  logic [W-1:0]        aluBQ, aluBD;
  logic [1:0]          rspValidQ, rspValidD;
  logic [W-1:0]        rspResultQ, rspResultD;
  aluFlags_t           rspFlagsQ, rspFlagsD;

  logic [1:0]          grant_c;
  logic [1:0]          reqReady_c;
  aluFlags_t           qualFlags_c;

  rr_arb2 uArb (
    .reqValid (bus.req_valid),
    .last     (lastQ),
    .grant_c  (grant_c)
  );

  // Mask raw flags the current op does not define, so stale ALU flag
  // latches never reach a requester.
  always_comb begin
    qualFlags_c   = '0;
    qualFlags_c.c = op_sets_carry(aluOpQ) & alu_c;
    qualFlags_c.n = op_sets_nvz(aluOpQ) & alu_n;
    qualFlags_c.v = op_sets_nvz(aluOpQ) & alu_v;
    qualFlags_c.z = op_sets_nvz(aluOpQ) & alu_z;
  end

  // Next-state and next-output logic.
  always_comb begin
    stateD     = stateQ;
    settleD    = settleQ;
    ownerD     = ownerQ;
    lastD      = lastQ;
    aluOpD     = aluOpQ;
    aluAD      = aluAQ;
    aluBD      = aluBQ;
    rspValidD  = rspValidQ;
    rspResultD = rspResultQ;
    rspFlagsD  = rspFlagsQ;
    reqReady_c = 2'b00;

    case (stateQ)
      IDLE: begin
        // Gated by rst_n so req_ready reads 0 while reset is held.
        reqReady_c = rst_n ? grant_c : 2'b00;
        if (grant_c != 2'b00) begin
          ownerD  = grant_c[1];
          aluOpD  = grant_c[1] ? bus.req_op1 : bus.req_op0;
          aluAD   = grant_c[1] ? bus.req_a1  : bus.req_a0;
          aluBD   = grant_c[1] ? bus.req_b1  : bus.req_b0;
          settleD = SETTLE_W'(ALU_LAT);
          stateD  = EXEC;
        end
      end

      EXEC: begin
        settleD = settleQ - SETTLE_W'(1);
        if (settleQ == SETTLE_W'(1)) begin
          rspResultD = alu_result;
          rspFlagsD  = qualFlags_c;
          rspValidD  = ownerQ ? 2'b10 : 2'b01;
          stateD     = RESP;
        end
      end

      RESP: begin
        // Only the owner's rsp_ready completes the transaction.
        if (bus.rsp_ready[ownerQ]) begin
          rspValidD = 2'b00;
          // Recording the owner as last gives the other port priority next.
          lastD     = ownerQ;
          stateD    = IDLE;
        end
      end

      default: stateD = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= IDLE;
      settleQ    <= '0;
      ownerQ     <= 1'b0;
      lastQ      <= 1'b1;
      aluOpQ     <= '0;
      aluAQ      <= '0;
      aluBQ      <= '0;
      rspValidQ  <= 2'b00;
      rspResultQ <= '0;
      rspFlagsQ  <= '0;
    end else begin
      stateQ     <= stateD;
      settleQ    <= settleD;
      ownerQ     <= ownerD;
      lastQ      <= lastD;
      aluOpQ     <= aluOpD;
      aluAQ      <= aluAD;
      aluBQ      <= aluBD;
      rspValidQ  <= rspValidD;
      rspResultQ <= rspResultD;
      rspFlagsQ  <= rspFlagsD;
    end
  end

  assign bus.req_ready  = reqReady_c;
  assign bus.rsp_valid  = rspValidQ;
  assign bus.rsp_result = rspResultQ;
  assign bus.rsp_flags  = rspFlagsQ;
  assign alu_op         = aluOpQ;
  assign alu_a          = aluAQ;
  assign alu_b          = aluBQ;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: one instance with ALU_LAT=1 driven by directed and
// random stimulus against a transaction-level model, and one with ALU_LAT=4
// for latency and mid-transaction reset behaviour. A behavioural ALU sits
// next to each instance, as it would at the parent level.
module tb_alu_share_ctrl;

  localparam int unsigned W     = 32;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 4;

  logic clk;
  logic rstNA, rstNB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.W(W)) busA ();
  alu_share_ctrl_if #(.W(W)) busB ();

  logic [3:0]   aluOpA, aluOpB;
  logic [W-1:0] aluAA, aluBA, aluResA, aluAB, aluBB, aluResB;
  logic         aluCA, aluNA, aluVA, aluZA, aluCB, aluNB, aluVB, aluZB;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        n;
    logic        v;
    logic        z;
  } aluOut_t;

  // Behavioural ALU; non-arithmetic ops leave junk on C/V like a stale latch.
  function automatic aluOut_t aluEval(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    aluOut_t     o;
    logic [32:0] wide;
    o   = '0;
    o.c = a[0];
    o.v = b[0];
    case (op)
      4'd0:  o.res = a & b;
      4'd1:  o.res = a | b;
      4'd2:  o.res = a ^ b;
      4'd3:  o.res = ~a;
      4'd4, 4'd5, 4'd6: begin
        wide  = {1'b0, a} + {1'b0, b} + ((op == 4'd5) ? 33'd1 : 33'd0);
        o.res = wide[31:0];
        o.c   = wide[32];
        o.v   = (a[31] == b[31]) && (o.res[31] != a[31]);
      end
      4'd7, 4'd8, 4'd9: begin
        wide  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.res = wide[31:0];
        o.c   = wide[32];
        o.v   = (a[31] != b[31]) && (o.res[31] != a[31]);
      end
      4'd10: o.res = a << b[4:0];
      4'd11: o.res = a >> b[4:0];
      4'd12: o.res = 32'($signed(a) >>> b[4:0]);
      4'd13: o.res = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
      4'd14: o.res = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
      default: begin
        o.res = 32'd32;
        for (int i = 0; i < 32; i++) if (a[i]) o.res = 32'(31 - i);
      end
    endcase
    o.n = o.res[31];
    o.z = (o.res == 32'd0);
    return o;
  endfunction

  // Flags a requester may see: carry only for ADD/ADC/SUBC, N/V/Z only for ADDS/SUBS.
  function automatic logic [3:0] expFlags(input logic [3:0] op, input aluOut_t o);
    logic [3:0] f;
    f = 4'b0000;
    if (op inside {4'b0100, 4'b0101, 4'b1001}) f[3] = o.c;
    if (op inside {4'b0110, 4'b0111}) f[2:0] = {o.n, o.v, o.z};
    return f;
  endfunction

  aluOut_t outA, outB;
  assign outA    = aluEval(aluOpA, aluAA, aluBA);
  assign aluResA = outA.res;
  assign aluCA   = outA.c;
  assign aluNA   = outA.n;
  assign aluVA   = outA.v;
  assign aluZA   = outA.z;
  assign outB    = aluEval(aluOpB, aluAB, aluBB);
  assign aluResB = outB.res;
  assign aluCB   = outB.c;
  assign aluNB   = outB.n;
  assign aluVB   = outB.v;
  assign aluZB   = outB.z;

  alu_share_ctrl #(.ALU_LAT(LAT_A), .W(W)) dutA (
    .clk(clk), .rst_n(rstNA), .bus(busA),
    .alu_op(aluOpA), .alu_a(aluAA), .alu_b(aluBA), .alu_result(aluResA),
    .alu_c(aluCA), .alu_n(aluNA), .alu_v(aluVA), .alu_z(aluZA)
  );

  alu_share_ctrl #(.ALU_LAT(LAT_B), .W(W)) dutB (
    .clk(clk), .rst_n(rstNB), .bus(busB),
    .alu_op(aluOpB), .alu_a(aluAB), .alu_b(aluBB), .alu_result(aluResB),
    .alu_c(aluCB), .alu_n(aluNB), .alu_v(aluVB), .alu_z(aluZB)
  );

  int nChecks = 0;
  int nFail   = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model of port A: one outstanding job, when it was issued,
  // and which port went last.
  int          cycle    = 0;
  bit          busy     = 1'b0;
  int          issueCyc = 0;
  bit          ownerM   = 1'b0;
  logic [3:0]  opM;
  logic [31:0] aM, bM;
  bit          lastWin  = 1'b1;
  int          obsGrant[$];
  int          obsCyc[$];

  // One cycle on instance A: drive at negedge, check shortly after, then let
  // the model step across the coming rising edge.
  task automatic stepA(input logic [1:0] v, input logic [1:0] rr,
                       input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    logic [1:0] expRdy;
    logic [1:0] expVld;
    bit         rspDue;
    aluOut_t    e;
    @(negedge clk);
    busA.req_valid = v;
    busA.rsp_ready = rr;
    busA.req_op0 = op0; busA.req_a0 = a0; busA.req_b0 = b0;
    busA.req_op1 = op1; busA.req_a1 = a1; busA.req_b1 = b1;
    #1;
    expRdy = 2'b00;
    if (!busy) begin
      if (v == 2'b11) expRdy = lastWin ? 2'b01 : 2'b10;
      else            expRdy = v;
    end
    checkVal("req_ready", 64'(busA.req_ready), 64'(expRdy));
    rspDue = busy && (cycle >= issueCyc + int'(LAT_A) + 1);
    expVld = rspDue ? (ownerM ? 2'b10 : 2'b01) : 2'b00;
    checkVal("rsp_valid", 64'(busA.rsp_valid), 64'(expVld));
    if (rspDue) begin
      e = aluEval(opM, aM, bM);
      checkVal("rsp_result", 64'(busA.rsp_result), 64'(e.res));
      checkVal("rsp_flags", 64'(busA.rsp_flags), 64'(expFlags(opM, e)));
    end
    if (busy && cycle > issueCyc)
      checkVal("alu_inputs", {busA.req_op0 & 4'h0, 60'(0)} | 64'({aluOpA, aluAA[27:0], aluBA[31:0]}),
               64'({opM, aM[27:0], bM}));
    if ((v & busA.req_ready) != 2'b00) begin
      obsGrant.push_back(int'(busA.req_ready[1]));
      obsCyc.push_back(cycle);
    end
    if (rspDue && rr[ownerM]) begin
      busy    = 1'b0;
      lastWin = ownerM;
    end else if (!busy && expRdy != 2'b00) begin
      busy     = 1'b1;
      ownerM   = expRdy[1];
      opM      = expRdy[1] ? op1 : op0;
      aM       = expRdy[1] ? a1 : a0;
      bM       = expRdy[1] ? b1 : b0;
      issueCyc = cycle;
    end
    cycle++;
  endtask

  task automatic idleA(input int n);
    for (int i = 0; i < n; i++) stepA(2'b00, 2'b11, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic drainA();
    for (int i = 0; i < 20 && busy; i++) idleA(1);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] heldRes;
  int          lat;

  initial begin
    rstNA = 1'b0;
    rstNB = 1'b0;
    busA.req_valid = 2'b11; busA.rsp_ready = 2'b00;
    busA.req_op0 = 4'h0; busA.req_a0 = '0; busA.req_b0 = '0;
    busA.req_op1 = 4'h0; busA.req_a1 = '0; busA.req_b1 = '0;
    busB.req_valid = 2'b00; busB.rsp_ready = 2'b00;
    busB.req_op0 = 4'h0; busB.req_a0 = '0; busB.req_b0 = '0;
    busB.req_op1 = 4'h0; busB.req_a1 = '0; busB.req_b1 = '0;

    // Reset values, with both requests asserted.
    #12;
    checkVal("rst_req_ready", 64'(busA.req_ready), 64'(0));
    checkVal("rst_rsp_valid", 64'(busA.rsp_valid), 64'(0));
    checkVal("rst_rsp_result", 64'(busA.rsp_result), 64'(0));
    checkVal("rst_rsp_flags", 64'(busA.rsp_flags), 64'(0));
    checkVal("rst_alu", 64'({aluOpA, aluAA, aluBA[27:0]}), 64'(0));
    @(negedge clk);
    busA.req_valid = 2'b00;
    rstNA = 1'b1;
    rstNB = 1'b1;

    // Tie from reset: grants 0,1,0,1 three cycles apart.
    obsGrant.delete(); obsCyc.delete();
    for (int i = 0; i < 12; i++)
      stepA(2'b11, 2'b11, 4'h4, 32'(i), 32'd3, 4'h7, 32'd50, 32'(i));
    drainA();
    checkVal("tie_count", 64'(obsGrant.size()), 64'(4));
    for (int i = 0; i < obsGrant.size(); i++) begin
      checkVal("tie_port", 64'(obsGrant[i]), 64'(i % 2));
      if (i > 0) checkVal("tie_gap", 64'(obsCyc[i] - obsCyc[i-1]), 64'(3));
    end

    // Single add on port 0: carry out, zero result.
    stepA(2'b01, 2'b11, 4'h4, 32'hFFFF_FFFF, 32'h1, 4'h0, 32'h0, 32'h0);
    idleA(2);
    checkVal("add_vld", 64'(busA.rsp_valid), 64'(2'b01));
    checkVal("add_res", 64'(busA.rsp_result), 64'(0));
    checkVal("add_flags", 64'(busA.rsp_flags), 64'(4'b1000));
    drainA();

    // Signed overflow on port 1.
    stepA(2'b10, 2'b11, 4'h0, 32'h0, 32'h0, 4'h6, 32'h7FFF_FFFF, 32'h1);
    idleA(2);
    checkVal("ovf_vld", 64'(busA.rsp_valid), 64'(2'b10));
    checkVal("ovf_res", 64'(busA.rsp_result), 64'(32'h8000_0000));
    checkVal("ovf_flags", 64'(busA.rsp_flags), 64'(4'b0110));
    drainA();

    // SUBS setting Z, then an AND with a zero result: AND must report no flags.
    stepA(2'b01, 2'b11, 4'h7, 32'h1234, 32'h1234, 4'h0, 32'h0, 32'h0);
    stepA(2'b01, 2'b11, 4'h0, 32'hF0F0, 32'h0F0F, 4'h0, 32'h0, 32'h0);
    stepA(2'b01, 2'b11, 4'h0, 32'hF0F0, 32'h0F0F, 4'h0, 32'h0, 32'h0);
    checkVal("subs_flags", 64'(busA.rsp_flags), 64'(4'b0001));
    stepA(2'b01, 2'b11, 4'h0, 32'hF0F0, 32'h0F0F, 4'h0, 32'h0, 32'h0);
    idleA(2);
    checkVal("mask_res", 64'(busA.rsp_result), 64'(0));
    checkVal("mask_flags", 64'(busA.rsp_flags), 64'(0));
    drainA();

    // Backpressure on port 0 for 5 cycles, with port 1 waiting and its
    // rsp_ready high (must be ignored).
    stepA(2'b01, 2'b11, 4'h4, 32'd5, 32'd6, 4'h4, 32'd1, 32'd2);
    stepA(2'b10, 2'b11, 4'h4, 32'd5, 32'd6, 4'h4, 32'd1, 32'd2);
    heldRes = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      stepA(2'b10, 2'b10, 4'h4, 32'd5, 32'd6, 4'h4, 32'd1, 32'd2);
      if (i == 0) heldRes = busA.rsp_result;
      checkVal("bp_vld", 64'(busA.rsp_valid), 64'(2'b01));
      checkVal("bp_res", 64'(busA.rsp_result), 64'(heldRes));
      checkVal("bp_rdy", 64'(busA.req_ready), 64'(0));
    end
    checkVal("bp_val", 64'(heldRes), 64'(11));
    stepA(2'b10, 2'b01, 4'h4, 32'd5, 32'd6, 4'h4, 32'd1, 32'd2);
    stepA(2'b10, 2'b11, 4'h4, 32'd5, 32'd6, 4'h4, 32'd1, 32'd2);
    checkVal("bp_done_vld", 64'(busA.rsp_valid), 64'(0));
    checkVal("bp_next_grant", 64'(busA.req_ready), 64'(2'b10));
    drainA();

    // Random traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] rv, rr;
      rv = 2'($urandom_range(0, 3));
      rr = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      stepA(rv, rr, 4'($urandom_range(0, 15)), pickOperand(), pickOperand(),
            4'($urandom_range(0, 15)), pickOperand(), pickOperand());
    end
    drainA();

    // ALU_LAT=4: latency of one port-0 add.
    @(negedge clk);
    busB.req_valid = 2'b01; busB.req_op0 = 4'h4; busB.req_a0 = 32'd100; busB.req_b0 = 32'd23;
    busB.rsp_ready = 2'b11;
    #1 checkVal("b_rdy0", 64'(busB.req_ready), 64'(2'b01));
    lat = 0;
    do begin
      @(negedge clk);
      busB.req_valid = 2'b00;
      #1;
      lat++;
      if (lat == 1) checkVal("b_alu_a", 64'(aluAB), 64'(100));
    end while (busB.rsp_valid == 2'b00 && lat < 20);
    checkVal("b_latency", 64'(lat), 64'(LAT_B + 1));
    checkVal("b_vld", 64'(busB.rsp_valid), 64'(2'b01));
    checkVal("b_res", 64'(busB.rsp_result), 64'(123));

    // Port 1 issue, reset in the 2nd EXEC cycle.
    @(negedge clk);
    busB.req_valid = 2'b10; busB.req_op1 = 4'h7; busB.req_a1 = 32'd9; busB.req_b1 = 32'd9;
    #1 checkVal("b_rdy1", 64'(busB.req_ready), 64'(2'b10));
    @(negedge clk);
    busB.req_valid = 2'b00;
    @(negedge clk);
    busB.req_valid = 2'b11;
    rstNB = 1'b0;
    #1;
    checkVal("b_rst_alu_op", 64'(aluOpB), 64'(0));
    checkVal("b_rst_alu_a", 64'(aluAB), 64'(0));
    checkVal("b_rst_alu_b", 64'(aluBB), 64'(0));
    checkVal("b_rst_vld", 64'(busB.rsp_valid), 64'(0));
    checkVal("b_rst_res", 64'(busB.rsp_result), 64'(0));
    checkVal("b_rst_flags", 64'(busB.rsp_flags), 64'(0));
    checkVal("b_rst_rdy", 64'(busB.req_ready), 64'(0));
    repeat (2) @(negedge clk);
    busB.req_valid = 2'b00;
    rstNB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 checkVal("b_no_rsp", 64'(busB.rsp_valid), 64'(0));
      @(negedge clk);
    end
    busB.req_valid = 2'b11;
    #1 checkVal("b_tie_after_rst", 64'(busB.req_ready), 64'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
